// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and the level type.
package fifo_pkg;

  localparam int unsigned PTR_SIZE = 5;

  // Occupancy type for the default pointer width (includes the wrap bit).
  typedef logic [PTR_SIZE-1:0] level_t;

  // Conversions operate on 32 bits; narrower pointers zero-extend harmlessly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter, zero latency, no flow control.
module gray_to_binary
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule

// File: rtl/read_level_flag_gen.sv
// Async-FIFO read side: pointer, fill level, empty and hysteretic almost-empty; one-edge latency.
// Reads while empty are dropped; define READ_UNDERFLOW_EN to add a sticky underflow_error.
module read_level_flag_gen
  import fifo_pkg::*;
#(
  parameter int SIZE       = 5,
  parameter int AE_DEFAULT = 2,
  parameter int AE_HYST    = 1
) (
  input  logic            read_clk,
  input  logic            read_rst_n,
  input  logic [SIZE-1:0] write_gray_pointer,
  input  logic            read_enable,
  input  logic [SIZE-1:0] almost_empty_threshold,
  output logic [SIZE-1:0] read_bin_pointer,
  output logic [SIZE-1:0] read_gray_pointer,
  output logic [SIZE-1:0] fill_level,
  output logic            empty_flag,
  output logic            almost_empty_flag
`ifdef READ_UNDERFLOW_EN
  ,
  output logic            underflow_error
`endif
);

  logic            rd_ok;
  logic [SIZE-1:0] write_bin;
  logic [SIZE-1:0] read_bin_next;
  logic [SIZE-1:0] read_gray_next;
  logic [SIZE-1:0] level_next;
  logic [SIZE-1:0] thr_eff;
  logic [SIZE:0]   clr_level;
  logic            ae_set;
  logic            ae_clr;

  gray_to_binary #(.WIDTH(SIZE)) u_wr_g2b (
    .gray (write_gray_pointer),
    .bin  (write_bin)
  );

  assign rd_ok          = read_enable & ~empty_flag;
  assign read_bin_next  = read_bin_pointer + SIZE'(rd_ok);
  assign read_gray_next = SIZE'(bin2gray(32'(read_bin_next)));
  // Modulo subtraction keeps the level correct across either pointer wrapping.
  assign level_next     = write_bin - read_bin_next;

  assign thr_eff   = (almost_empty_threshold == '0) ? SIZE'(AE_DEFAULT) : almost_empty_threshold;
  // One bit wider so a large threshold plus hysteresis cannot wrap.
  assign clr_level = {1'b0, thr_eff} + (SIZE+1)'(AE_HYST + 1);
  assign ae_set    = (level_next <= thr_eff);
  assign ae_clr    = ({1'b0, level_next} >= clr_level);

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      read_bin_pointer  <= '0;
      read_gray_pointer <= '0;
      fill_level        <= '0;
      empty_flag        <= 1'b1;
      almost_empty_flag <= 1'b1;
    end else begin
      read_bin_pointer  <= read_bin_next;
      read_gray_pointer <= read_gray_next;
      fill_level        <= level_next;
      empty_flag        <= (read_gray_next == write_gray_pointer);
      if (ae_set) begin
        almost_empty_flag <= 1'b1;
      end else if (ae_clr) begin
        almost_empty_flag <= 1'b0;
      end
    end
  end

`ifdef READ_UNDERFLOW_EN
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      underflow_error <= 1'b0;
    end else if (read_enable && empty_flag) begin
      underflow_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_read_level_flag_gen.sv
// Directed bench for read_level_flag_gen (SIZE=5, AE_DEFAULT=2, AE_HYST=1).
module tb_read_level_flag_gen;

  logic       read_clk;
  logic       read_rst_n;
  logic [4:0] write_gray_pointer;
  logic       read_enable;
  logic [4:0] almost_empty_threshold;
  logic [4:0] read_bin_pointer;
  logic [4:0] read_gray_pointer;
  logic [4:0] fill_level;
  logic       empty_flag;
  logic       almost_empty_flag;
`ifdef READ_UNDERFLOW_EN
  logic       underflow_error;
`endif

  int checks   = 0;
  int failures = 0;

  read_level_flag_gen #(.SIZE(5), .AE_DEFAULT(2), .AE_HYST(1)) dut (
    .read_clk               (read_clk),
    .read_rst_n             (read_rst_n),
    .write_gray_pointer     (write_gray_pointer),
    .read_enable            (read_enable),
    .almost_empty_threshold (almost_empty_threshold),
    .read_bin_pointer       (read_bin_pointer),
    .read_gray_pointer      (read_gray_pointer),
    .fill_level             (fill_level),
    .empty_flag             (empty_flag),
    .almost_empty_flag      (almost_empty_flag)
`ifdef READ_UNDERFLOW_EN
    ,
    .underflow_error        (underflow_error)
`endif
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge read_clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int fl, input logic em, input logic ae);
    check({tag, ".fill"}, 32'(fill_level), 32'(fl));
    check({tag, ".empty"}, 32'(empty_flag), 32'(em));
    check({tag, ".ae"}, 32'(almost_empty_flag), 32'(ae));
  endtask

  initial begin
    int  lvl;
    logic ae_m;

    read_rst_n = 1'b0;
    write_gray_pointer = '0;
    read_enable = 1'b0;
    almost_empty_threshold = '0;
    #12;
    check_state("rst", 0, 1'b1, 1'b1);
    check("rst.rbin", 32'(read_bin_pointer), 32'd0);
    check("rst.rgray", 32'(read_gray_pointer), 32'd0);
`ifdef READ_UNDERFLOW_EN
    check("rst.uf", 32'(underflow_error), 32'd0);
`endif
    @(posedge read_clk); #1;
    read_rst_n = 1'b1;
    step();
    check_state("idle", 0, 1'b1, 1'b1);

    // Four entries arrive; 4 >= 2+1+1 clears almost-empty.
    write_gray_pointer = g(4);
    step();
    check_state("fill4", 4, 1'b0, 1'b0);

    // Drain one per cycle.
    read_enable = 1'b1;
    step(); check_state("rd3", 3, 1'b0, 1'b0);
    check("rd3.rbin", 32'(read_bin_pointer), 32'd1);
    step(); check_state("rd2", 2, 1'b0, 1'b1);
    step(); check_state("rd1", 1, 1'b0, 1'b1);
    step(); check_state("rd0", 0, 1'b1, 1'b1);
    check("rd0.rbin", 32'(read_bin_pointer), 32'd4);
    check("rd0.rgray", 32'(read_gray_pointer), 32'(g(4)));
    step();
    check("rej.rbin", 32'(read_bin_pointer), 32'd4);
`ifdef READ_UNDERFLOW_EN
    check("rej.uf", 32'(underflow_error), 32'd1);
`endif
    read_enable = 1'b0;

    // Hysteresis: set at 2, hold at 3, clear at 4.
    write_gray_pointer = g(6); step(); check_state("hy2", 2, 1'b0, 1'b1);
    write_gray_pointer = g(7); step(); check_state("hy3", 3, 1'b0, 1'b1);
    write_gray_pointer = g(8); step(); check_state("hy4", 4, 1'b0, 1'b0);

    // Programmable threshold 8.
    write_gray_pointer = g(14);
    almost_empty_threshold = 5'd8;
    step(); check_state("t8_10", 10, 1'b0, 1'b0);
    read_enable = 1'b1;
    step(); check_state("t8_9", 9, 1'b0, 1'b0);
    step(); check_state("t8_8", 8, 1'b0, 1'b1);
    read_enable = 1'b0;
    almost_empty_threshold = 5'd0;
    step(); check_state("t0_8", 8, 1'b0, 1'b0);

    // Simultaneous write and read in one cycle.
    write_gray_pointer = g(16);
    read_enable = 1'b1;
    step(); check_state("simul", 9, 1'b0, 1'b0);
    check("simul.rbin", 32'(read_bin_pointer), 32'd7);
    read_enable = 1'b0;

    // Asynchronous reset mid-operation with a read pending.
    read_enable = 1'b1;
    #2;
    read_rst_n = 1'b0;
    #1;
    check_state("mrst", 0, 1'b1, 1'b1);
    check("mrst.rbin", 32'(read_bin_pointer), 32'd0);
`ifdef READ_UNDERFLOW_EN
    check("mrst.uf", 32'(underflow_error), 32'd0);
`endif
    read_enable = 1'b0;
    write_gray_pointer = '0;
    @(posedge read_clk); #1;
    read_rst_n = 1'b1;

    // Full FIFO, then stream a read and a write per cycle across the write wrap.
    write_gray_pointer = g(16);
    step(); check_state("full", 16, 1'b0, 1'b0);
    read_enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      write_gray_pointer = g(16 + i);
      step();
      check("wrapw.fill", 32'(fill_level), 32'd16);
      check("wrapw.rbin", 32'(read_bin_pointer), 32'(i));
    end

    // Drain across the read-pointer wrap with a small almost-empty model.
    ae_m = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      lvl = 16 - i;
      if (lvl <= 2) ae_m = 1'b1;
      else if (lvl >= 4) ae_m = 1'b0;
      check_state("wrapr", lvl, (lvl == 0), ae_m);
    end
    check("wrapr.rbin", 32'(read_bin_pointer), 32'd4);
    check("wrapr.rgray", 32'(read_gray_pointer), 32'(g(4)));
    step();
    check("uf.rbin", 32'(read_bin_pointer), 32'd4);
`ifdef READ_UNDERFLOW_EN
    check("uf.flag", 32'(underflow_error), 32'd1);
`endif
    read_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/read_level_flag_gen.md
READ_LEVEL_FLAG_GEN -- requirements
Module: read_level_flag_gen

Interface
REQ-001 SHALL have parameter SIZE, default 5: pointer width including wrap bit; FIFO depth DEPTH = 2**(SIZE-1).
REQ-002 SHALL have parameter AE_DEFAULT, default 2: almost-empty threshold used when threshold input is 0.
REQ-003 SHALL have parameter AE_HYST, default 1: hysteresis width in entries, range 0..DEPTH-1.
REQ-004 read_clk  input  1  read-domain clock.
REQ-005 read_rst_n  input  1  asynchronous active-low reset.
REQ-006 write_gray_pointer  input  SIZE  write pointer, Gray, already synchronised into read_clk.
REQ-007 read_enable  input  1  read request.
REQ-008 almost_empty_threshold  input  SIZE  programmable threshold; 0 selects AE_DEFAULT.
REQ-009 read_bin_pointer  output  SIZE  registered binary read pointer.
REQ-010 read_gray_pointer  output  SIZE  registered Gray read pointer, sent to the write-domain synchroniser.
REQ-011 fill_level  output  SIZE  registered occupancy, 0..DEPTH.
REQ-012 empty_flag  output  1  registered empty.
REQ-013 almost_empty_flag  output  1  registered almost-empty with hysteresis.
REQ-014 underflow_error  output  1  sticky underflow; present only with READ_UNDERFLOW_EN (REQ-030).

Function
REQ-015 Read accepted (rd_ok) SHALL equal read_enable AND NOT empty_flag; a rejected read changes no state.
REQ-016 On rd_ok, read_bin_pointer SHALL increment by 1 modulo 2**SIZE; read_gray_pointer SHALL be (bin>>1)^bin of the new value, both updated on the same edge.
REQ-017 Write pointer SHALL be Gray-to-binary converted combinationally each cycle.
REQ-018 Next level SHALL be (write_bin - read_bin_next) modulo 2**SIZE, SIZE bits, no saturation; fill_level SHALL register it.
REQ-019 empty_flag SHALL register (read_gray_next == write_gray_pointer); a read of the last entry asserts empty on the same edge that advances the pointer (zero-bubble).
REQ-020 Effective threshold T = almost_empty_threshold, or AE_DEFAULT if that input is 0; sampled every cycle.
REQ-021 almost_empty_flag SHALL set when level_next <= T and clear only when level_next >= T + AE_HYST + 1; otherwise hold.
REQ-022 With AE_HYST = 0, almost_empty_flag SHALL equal registered (level_next <= T).
REQ-023 Empty SHALL imply almost_empty (level 0 <= T always holds).
REQ-024 Pointer wrap SHALL be seamless: level and flags correct across 2**SIZE-1 -> 0 transitions of either pointer.
REQ-025 Simultaneous write-pointer change and rd_ok SHALL both be reflected in the same-cycle level_next.
REQ-026 Latency: rd_ok or write-pointer change visible on all outputs one read_clk edge later.

Reset
REQ-027 On read_rst_n low, asynchronously: pointers 0, fill_level 0, empty_flag 1, almost_empty_flag 1, underflow_error 0.
REQ-028 Reset mid-operation SHALL abandon any read in progress; first rd_ok possible the cycle after release once empty_flag is 0.
REQ-029 Reset release SHALL be synchronous to read_clk externally; block adds no synchroniser.

Configuration
REQ-030 Macro READ_UNDERFLOW_EN defined: underflow_error sets on read_enable while empty_flag is 1, stays set until reset.
REQ-031 READ_UNDERFLOW_EN undefined: underflow_error port and logic absent; rejected reads silently dropped.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the gray-to-binary and binary-to-gray functions and a SIZE-parameterised level type.
REQ-033 Gray-to-binary conversion SHALL reuse sub-module gray_to_binary; flag/hysteresis logic stays in this module.

Verification (SIZE=5, DEPTH=16, AE_DEFAULT=2, AE_HYST=1)
REQ-034 Reset, write_gray=0 -> empty=1, almost_empty=1, fill_level=0, pointers 0.
REQ-035 write_gray to binary 4, no reads -> next edge empty=0, fill_level=4, almost_empty=0 (4 >= 2+1+1).
REQ-036 Level 4, read each cycle -> levels 3,2,1,0; almost_empty sets at level 2, empty sets at level 0 on the edge of the 4th read.
REQ-037 Level 2 (AE set), write to level 3 -> AE stays 1; level 4 -> AE clears.
REQ-038 Threshold input 8, level 10 -> AE 0; read to 8 -> AE 1; threshold back to 0 at level 8 -> AE holds 1 until level >= 4 cleared path (level 8 >= 4, clears next edge).
REQ-039 Pointers near 31, fill and drain across wrap -> fill_level continuous; with READ_UNDERFLOW_EN, read_enable while empty -> underflow_error=1, pointer unchanged.
